// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// ----------------
// Instruction fetch unit with a small in-order instruction queue. Each cycle
// it may issue one read to a synchronous instruction ROM. The read data
// returns one cycle later and is pushed into the queue, tagged with the
// address it was fetched from. Decode pops the queue head with a
// valid/ready handshake. A redirect (flush) or a reset empties the queue,
// drops any read still in flight and restarts fetch at the new address.
//
// Compile-time option:
//   IFQ_STALL_CNT_EN  when defined, stall_cnt counts the cycles in which decode
//                     was starved (no valid head, no flush). The counter
//                     saturates at 16'hFFFF. When the macro is not defined,
//                     stall_cnt is tied to 0.
//
// Parameters:
//   DEPTH     queue depth in entries (power of two, 2..16)
//   PC_RESET  fetch address loaded on reset
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   imem_en     ROM read request (combinational from registered state)
//   imem_addr   ROM byte address (the fetch PC)
//   imem_rdata  ROM data, valid the cycle after imem_en
//   flush       redirect request
//   flush_pc    redirect target, sampled when flush=1
//   inst_valid  queue head is valid
//   inst_ready  decode accepts the head this cycle
//   inst_code   head instruction word (0 when not valid)
//   inst_pc     head instruction address (0 when not valid)
//   count       number of valid queue entries
//   stall_cnt   decode-starvation counter
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_code,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [31:0]   pc_reg;
  logic          inflight_reg;
  logic [31:0]   inflight_pc_reg;
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic [31:0]   code_mem [DEPTH];
  logic [31:0]   tag_mem  [DEPTH];

  logic [CW:0]   credit_sum;
  logic          push;
  logic          pop;

  // An outstanding read already owns a queue slot, so it is counted against
  // the depth. This guarantees a free slot whenever its data arrives.
  assign credit_sum = {1'b0, count_reg} + (CW + 1)'(inflight_reg);
  assign imem_en    = !rst && !flush && (credit_sum < DEPTH_LIM);
  assign imem_addr  = pc_reg;

  // A flush or reset at the edge where the data lands discards that data.
  assign push = inflight_reg && !flush && !rst;
  // A flush wins over inst_ready. The head is dropped, not consumed.
  assign pop  = inst_valid && inst_ready && !flush;

  assign inst_valid = !rst && (count_reg != '0);
  assign inst_code  = inst_valid ? code_mem[head_reg] : 32'h0;
  assign inst_pc    = inst_valid ? tag_mem[head_reg]  : 32'h0;
  assign count      = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= PC_RESET;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
    end else if (flush) begin
      pc_reg          <= flush_pc;
      inflight_reg    <= 1'b0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
    end else begin
      if (imem_en) begin
        pc_reg <= pc_reg + 32'd4;
      end
      inflight_reg    <= imem_en;
      inflight_pc_reg <= pc_reg;
      if (push) begin
        tail_reg <= tail_reg + PW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  // The queue storage is not reset. An entry is only read after a push
  // has written it.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[tail_reg] <= imem_rdata;
      tag_mem[tail_reg]  <= inflight_pc_reg;
    end
  end

`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 16'h0;
    end else if (!inst_valid && !flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue.
//
// The ROM returns word n at byte address 4n. When no read is requested, the
// ROM returns random data.
//
// The reference model is the fetch stream that software expects: after every
// redirect (reset or flush), decode must see the addresses target,
// target+4, target+8, ... in order, each carrying its ROM word. The stimulus
// pushes the next expected address every cycle it drives. A negedge monitor
// pops and compares the expected entry each time decode accepts the head. The
// monitor also checks output invariants. Directed phases cover latency,
// back-pressure, flush, wrap and reset. A randomized phase follows.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
`ifdef IFQ_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd2;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [2:0]  count;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] next_exp_pc;
  logic [31:0] exp_fetch_pc;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .flush(flush), .flush_pc(flush_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_code(inst_code),
    .inst_pc(inst_pc), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom(imem_addr);
    else         imem_rdata <= $urandom();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then waits for the
  // falling edge so that directed checks read settled outputs.
  task automatic cyc(input logic r, input logic f, input logic [31:0] fpc, input logic rdy);
    @(posedge clk);
    #1;
    rst        = r;
    flush      = f;
    flush_pc   = fpc;
    inst_ready = rdy;
    if (r || f) begin
      exp_q.delete();
      next_exp_pc  = r ? PC_RESET : fpc;
      exp_fetch_pc = next_exp_pc;
    end else begin
      exp_q.push_back(next_exp_pc);
      next_exp_pc = next_exp_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_code", inst_code, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
      end else begin
        check("valid_vs_count", 32'(inst_valid), 32'(count != 3'd0));
        check("count_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
        if (!inst_valid) begin
          check("idle_code", inst_code, 32'h0);
          check("idle_pc", inst_pc, 32'h0);
        end
        if (flush) check("flush_imem_en", 32'(imem_en), 32'd0);
        if (count == 3'(DEPTH)) check("full_imem_en", 32'(imem_en), 32'd0);
        if (imem_en) begin
          check("fetch_addr", imem_addr, exp_fetch_pc);
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (inst_valid && inst_ready && !flush) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got pc %h expected no pop", inst_pc);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            $display("pop pc=%h code=%h", inst_pc, inst_code);
            check("pop_pc", inst_pc, e);
            check("pop_code", inst_code, rom(e));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tmp;
    logic r, f, rdy;
    rst = 1'b1; flush = 1'b0; flush_pc = 32'h0; inst_ready = 1'b0;
    next_exp_pc = PC_RESET; exp_fetch_pc = PC_RESET;

    // Reset, then free-running fetch with decode always ready.
    cyc(1, 0, 0, 1);
    mon_en = 1'b1;
    cyc(1, 0, 0, 1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_addr", imem_addr, PC_RESET);
    cyc(0, 0, 0, 1);
    check("c0_en", 32'(imem_en), 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", 32'(inst_valid), 32'd0);
    cyc(0, 0, 0, 1);
    check("c1_addr", imem_addr, 32'h4);
    check("c1_valid", 32'(inst_valid), 32'd0);
    cyc(0, 0, 0, 1);
    check("c2_valid", 32'(inst_valid), 32'd1);
    check("c2_pc", inst_pc, 32'h0);
    check("c2_code", inst_code, 32'h0);
    check("c2_addr", imem_addr, 32'h8);
    cyc(0, 0, 0, 1);
    check("c3_pc", inst_pc, 32'h4);
    check("c3_code", inst_code, 32'h1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    check("stall_warm", 32'(stall_cnt), STALL_EXP);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    check("stall_hold", 32'(stall_cnt), STALL_EXP);

    // Back-pressure: the queue fills and fetch stops.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_en", 32'(imem_en), 32'd0);
    check("full_addr", imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      check("drain_pc", inst_pc, 32'(4 * i));
      check("drain_code", inst_code, 32'(i));
    end

    // Flush with three entries queued and one read in flight.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check("preflush_count", 32'(count), 32'd3);
    check("preflush_en", 32'(imem_en), 32'd0);
    cyc(0, 1, 32'h100, 1);
    cyc(0, 0, 0, 1);
    check("postflush_count", 32'(count), 32'd0);
    check("postflush_addr", imem_addr, 32'h100);
    check("postflush_en", 32'(imem_en), 32'd1);
    check("postflush_valid", 32'(inst_valid), 32'd0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("flush_first_pc", inst_pc, 32'h100);
    check("flush_first_code", inst_code, 32'h40);

    // Fetch address wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    cyc(0, 0, 0, 1);
    check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    check("wrap_a2", imem_addr, 32'h0);
    check("wrap_p0", inst_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    check("wrap_p1", inst_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    check("wrap_p2", inst_pc, 32'h0);

    // One-cycle reset pulse with two entries queued.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    check("prerst_count", 32'(count), 32'd2);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("postrst_valid", 32'(inst_valid), 32'd0);
    check("postrst_count", 32'(count), 32'd0);
    check("postrst_addr", imem_addr, PC_RESET);
    check("postrst_en", 32'(imem_en), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      f   = !r && ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tmp = $urandom();
      cyc(r, f, {tmp[31:2], 2'b00}, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the instruction queue depth in entries (power of two, 2..16).
REQ-002 Parameter PC_RESET, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-003 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port imem_en  output  1  read request to instruction ROM, combinational from registered state.
REQ-007 Port imem_addr  output  32  byte address of the request; equals the internal PC.
REQ-008 Port imem_rdata  input  32  ROM read data, valid exactly one cycle after the imem_en cycle.
REQ-009 Port flush  input  1  redirect request.
REQ-010 Port flush_pc  input  32  new fetch address, sampled when flush=1.
REQ-011 Port inst_valid  output  1  queue head holds a valid instruction.
REQ-012 Port inst_ready  input  1  decode stage accepts the head this cycle.
REQ-013 Port inst_code  output  32  head instruction word; 0 when inst_valid=0.
REQ-014 Port inst_pc  output  32  byte address of the head instruction; 0 when inst_valid=0.
REQ-015 Port count  output  $clog2(DEPTH)+1  number of valid queue entries.
REQ-016 Port stall_cnt  output  16  decode-starvation counter (see Configuration).

Function
REQ-017 imem_en SHALL be 1 iff rst=0, flush=0, and count + inflight < DEPTH, where inflight (0 or 1) marks a request issued in the previous cycle.
REQ-018 On each edge with imem_en=1, PC SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 A response SHALL be pushed at the edge ending the cycle after its request, tagged with the request address.
REQ-020 Minimum latency: request in cycle C -> inst_valid=1 from cycle C+2.
REQ-021 A pop SHALL occur on an edge with inst_valid=1 and inst_ready=1; inst_ready with inst_valid=0 SHALL have no effect.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 The queue SHALL never overflow; the REQ-017 credit rule guarantees push only when count < DEPTH after the same-edge pop.
REQ-024 With count = DEPTH and no pop, imem_en SHALL be 0 and PC SHALL hold.
REQ-025 On flush=1: at that edge, queue cleared (count=0), PC <= flush_pc, and no pop is counted; an in-flight response arriving the following cycle SHALL be discarded.
REQ-026 flush asserted together with inst_ready SHALL take priority; the head is dropped, not consumed.
REQ-027 Fetch resumes in the cycle after flush with imem_addr = flush_pc.
REQ-028 Head/tail pointers wrap modulo DEPTH.

Reset
REQ-029 On rst=1 at an edge: PC=PC_RESET, count=0, inflight=0, pointers=0, stall_cnt=0.
REQ-030 While rst=1: imem_en=0, inst_valid=0, inst_code=0, inst_pc=0.
REQ-031 rst mid-operation SHALL discard all queued and in-flight instructions; the response arriving in the cycle after reset SHALL be ignored.

Configuration
REQ-032 Macro IFQ_STALL_CNT_EN defined: stall_cnt increments by 1 (saturating at 16'hFFFF) on each non-reset edge where inst_valid=0 and flush=0.
REQ-033 Macro IFQ_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic is synthesized.

Verification
REQ-034 Reset release, inst_ready=1, ROM word[n]=n -> imem_addr 0,4,8,... each cycle; first inst_valid two cycles after first request, inst_code=0, inst_pc=0, then one per cycle.
REQ-035 inst_ready=0 for 10 cycles -> count saturates at 4, imem_en=0, PC=16; inst_ready=1 -> entries pop in order 0,1,2,3 with no loss/duplicate.
REQ-036 flush=1, flush_pc=32'h100 while count=3 and a request in flight -> next cycle count=0, imem_addr=32'h100; first inst_pc after flush=32'h100; stale word never appears.
REQ-037 PC_RESET=32'hFFFF_FFF8, free-running -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst pulsed one cycle with count=2 -> inst_valid=0 next cycle, refetch restarts at PC_RESET.
REQ-039 With IFQ_STALL_CNT_EN, inst_ready held 1 from reset -> stall_cnt=2 after warm-up and stays 2; without macro stall_cnt=0 throughout.
